pc_unit: RTL and testbench

- Program-counter datapath slice for the single-cycle MIPS core.
- Holds the 32-bit PC in a register. A ripple-carry adder built from 1-bit full-adder cells forms the sequential next address.
- A 2:1 mux selects the next PC: the sequential address, or an externally supplied target (branch/jump address from the control/ALU path).
- Feeds the instruction-memory address and the PC+INC value used by branch/link logic.

---
 rtl/pc_unit.sv | 68 ++++++
 tb/tb_pc_unit.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/pc_unit.sv
// Program-counter slice for the single-cycle MIPS core.
// Holds the PC and forms PC+INC with a ripple chain of 1-bit full-adder cells.
// A 2:1 mux selects either the sequential address or an external target.
module pc_unit #(
  parameter int                 WIDTH     = 32,
  parameter int                 INC       = 4,
  parameter logic [WIDTH-1:0]   RESET_VEC = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             pc_src,
  input  logic [WIDTH-1:0] target,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_next,
  output logic [WIDTH-1:0] pc_plus,
  output logic             carry_out
);

  // Increment operand for the adder chain, as a WIDTH-bit vector.
  localparam logic [WIDTH-1:0] INC_VEC = WIDTH'(INC);

  // Sum bit of a 1-bit full-adder cell.
  function automatic logic fa_sum(input logic a, input logic b, input logic cin);
    fa_sum = a ^ b ^ cin;
  endfunction

  // Carry bit of a 1-bit full-adder cell.
  function automatic logic fa_cout(input logic a, input logic b, input logic cin);
    fa_cout = (a & b) | (cin & (a ^ b));
  endfunction

  logic [WIDTH-1:0] pc_r;
  logic [WIDTH-1:0] sum_s;
  logic [WIDTH:0]   carry_s;
  logic [WIDTH-1:0] next_s;

  // The chain starts with no carry in.
  assign carry_s[0] = 1'b0;

  // One full-adder cell per bit. Each cell's carry ripples into the next one.
  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    assign sum_s[i]     = fa_sum (pc_r[i], INC_VEC[i], carry_s[i]);
    assign carry_s[i+1] = fa_cout(pc_r[i], INC_VEC[i], carry_s[i]);
  end

  // The ternary is deliberate: an unknown pc_src merges both candidates,
  // so X shows up on pc_next instead of the target being picked silently.
  assign next_s = pc_src ? sum_s : target;

  // PC register: asynchronous reset to the reset vector, loads when enabled,
  // and otherwise holds (stall).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_r <= RESET_VEC;
    end else if (en) begin
      pc_r <= next_s;
    end else begin
      pc_r <= pc_r;
    end
  end

  assign pc        = pc_r;
  assign pc_next   = next_s;
  assign pc_plus   = sum_s;
  assign carry_out = carry_s[WIDTH];

endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit. Each step pushes the PC value the bench expects
// after the next clock edge onto a scoreboard queue. That value is popped and
// compared once the edge has passed.
module tb_pc_unit;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic        pc_src;
  logic [31:0] target;
  logic [31:0] pc;
  logic [31:0] pc_next;
  logic [31:0] pc_plus;
  logic        carry_out;

  int unsigned pass_cnt  = 0;
  int unsigned total_cnt = 0;
  logic [31:0] model_pc;
  logic [31:0] sb_q[$];

  pc_unit #(.WIDTH(32), .INC(4), .RESET_VEC(32'h0000_0000)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .pc_src    (pc_src),
    .target    (target),
    .pc        (pc),
    .pc_next   (pc_next),
    .pc_plus   (pc_plus),
    .carry_out (carry_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stops the run if something stalls it.
  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish, observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // Runs one comparison and counts it.
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Checks the combinational outputs that follow from the model PC.
  task automatic chk_comb(input string tag);
    logic [32:0] wide;
    wide = {1'b0, model_pc} + 33'd4;
    chk({tag, " pc_plus"}, pc_plus, wide[31:0]);
    chk({tag, " carry_out"}, {31'd0, carry_out}, {31'd0, wide[32]});
  endtask

  // Drives one cycle of stimulus and checks the outputs.
  // pc_next is checked before the edge. pc, pc_plus and carry_out are checked after it.
  task automatic step(input string tag, input logic e, input logic s, input logic [31:0] t);
    logic [31:0] nxt;
    en = e;
    pc_src = s;
    target = t;
    nxt = s ? (model_pc + 32'd4) : t;
    sb_q.push_back(e ? nxt : model_pc);
    #1;
    chk({tag, " pc_next"}, pc_next, nxt);
    @(posedge clk);
    #1;
    model_pc = sb_q.pop_front();
    chk({tag, " pc"}, pc, model_pc);
    chk_comb(tag);
  endtask

  initial begin
    rst_n = 1'b0;
    en = 1'b0;
    pc_src = 1'b1;
    target = 32'h0000_0000;
    model_pc = 32'h0000_0000;

    // Reset state.
    #12;
    chk("reset pc", pc, 32'h0000_0000);
    chk("reset pc_next", pc_next, 32'h0000_0004);
    chk_comb("reset");
    rst_n = 1'b1;

    // Sequential run: the PC steps 0x4 through 0x28.
    for (int i = 0; i < 10; i++) step("seq", 1'b1, 1'b1, 32'hDEAD_BEEF);
    chk("seq end pc", pc, 32'h0000_0028);

    // Load a target, then continue sequentially from it.
    step("load", 1'b1, 1'b0, 32'h0040_0000);
    step("load+4", 1'b1, 1'b1, 32'h0000_0000);
    chk("load+4 pc", pc, 32'h0040_0004);

    // Stall with pc_src toggling, then resume.
    step("stall0", 1'b0, 1'b0, 32'h0000_1234);
    step("stall1", 1'b0, 1'b1, 32'h0000_1234);
    step("stall2", 1'b0, 1'b0, 32'h0000_1234);
    chk("stall pc", pc, 32'h0040_0004);
    step("resume", 1'b1, 1'b1, 32'h0000_1234);
    chk("resume pc", pc, 32'h0040_0008);

    // Wrap-around at the top of the address space.
    step("wrapld", 1'b1, 1'b0, 32'hFFFF_FFFC);
    chk("wrap carry", {31'd0, carry_out}, 32'd1);
    chk("wrap pc_plus", pc_plus, 32'h0000_0000);
    step("wrap", 1'b1, 1'b1, 32'h0000_0000);
    chk("wrap pc", pc, 32'h0000_0000);
    chk("wrap carry0", {31'd0, carry_out}, 32'd0);

    // Asynchronous reset between clock edges.
    step("arst ld", 1'b1, 1'b0, 32'h0040_0010);
    en = 1'b1;
    pc_src = 1'b1;
    #3;
    rst_n = 1'b0;
    #1;
    model_pc = 32'h0000_0000;
    chk("arst pc", pc, 32'h0000_0000);
    chk_comb("arst");
    #1;
    rst_n = 1'b1;
    step("arst resume", 1'b1, 1'b1, 32'h0000_0000);
    chk("arst resume pc", pc, 32'h0000_0004);

    // Held target: the PC stays at 0x100.
    for (int i = 0; i < 5; i++) begin
      step("hold", 1'b1, 1'b0, 32'h0000_0100);
      chk("hold pc_plus", pc_plus, 32'h0000_0104);
    end
    chk("hold pc", pc, 32'h0000_0100);
    chk("hold pc_next", pc_next, 32'h0000_0100);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
